// File: rtl/traffic_controller_nway.sv
// N-approach adaptive signal controller: round-robin green service sized by per-approach
// vehicle counts, with yellow and all-red clearance, paced by an internal seconds tick.
module traffic_controller_nway #(
  parameter int N_WAYS      = 4,
  parameter int CNT_W       = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 30,
  parameter int SEC_PER_CAR = 2,
  parameter int YELLOW_T    = 3,
  parameter int ALL_RED_T   = 1
) (
  input  logic                        clk_50MHz,
  input  logic                        reset,
  input  logic [N_WAYS*CNT_W-1:0]     count,
  output logic [N_WAYS*3-1:0]         lights,
  output logic [$clog2(N_WAYS)-1:0]   active_way,
  output logic [7:0]                  sec_left,
  output logic [1:0]                  phase
);

  localparam int AW = $clog2(N_WAYS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = CNT_W + 8;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'b00,
    PH_GREEN   = 2'b01,
    PH_YELLOW  = 2'b10
  } phase_t;

  phase_t        phase_q, phase_d;
  logic [AW-1:0] active_q, active_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    glen_q, glen_d;
  logic [PW-1:0] presc_q, presc_d;

  logic             tick;
  logic [AW-1:0]    nxt_way;
  logic [CNT_W-1:0] nxt_cnt;
  logic [CNT_W-1:0] act_cnt;
  logic [8:0]       elapsed;

  function automatic logic [7:0] green_len(input logic [CNT_W-1:0] c);
    logic [GW-1:0] g;
    g = GW'(c) * GW'(SEC_PER_CAR);
    if (g < GW'(MIN_GREEN))
      g = GW'(MIN_GREEN);
    else if (g > GW'(MAX_GREEN))
      g = GW'(MAX_GREEN);
    return g[7:0];
  endfunction

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign act_cnt = count[active_q*CNT_W +: CNT_W];
  // Seconds of green already served, counting the second that closes on this tick.
  assign elapsed = {1'b0, glen_q} - {1'b0, sec_q} + 9'd1;

  // First non-empty approach after the current one; plain rotation when all are empty.
  always_comb begin
    int idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    nxt_way = AW'((int'(active_q) + 1) % N_WAYS);
    for (int k = 1; k <= N_WAYS; k++) begin
      idx = (int'(active_q) + k) % N_WAYS;
      if (!found && (count[idx*CNT_W +: CNT_W] != '0)) begin
        nxt_way = AW'(idx);
        found   = 1'b1;
      end
    end
    nxt_cnt = count[nxt_way*CNT_W +: CNT_W];
  end

  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    sec_d    = sec_q;
    glen_d   = glen_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    // Phase changes only happen on a tick, so the prescaler is already restarting.
    if (tick) begin
      sec_d = sec_q - 8'd1;
      case (phase_q)
        PH_ALL_RED: begin
          if (sec_q == 8'd1) begin
            phase_d  = PH_GREEN;
            active_d = nxt_way;
            sec_d    = green_len(nxt_cnt);
            glen_d   = green_len(nxt_cnt);
          end
        end
        PH_GREEN: begin
          if ((sec_q == 8'd1) ||
              ((elapsed >= 9'(MIN_GREEN)) && (act_cnt == '0))) begin
            phase_d = PH_YELLOW;
            sec_d   = 8'(YELLOW_T);
          end
        end
        PH_YELLOW: begin
          if (sec_q == 8'd1) begin
            phase_d = PH_ALL_RED;
            sec_d   = 8'(ALL_RED_T);
          end
        end
        default: begin
          phase_d = PH_ALL_RED;
          sec_d   = 8'(ALL_RED_T);
        end
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      phase_q  <= PH_ALL_RED;
      active_q <= AW'(N_WAYS - 1);
      sec_q    <= 8'(ALL_RED_T);
      glen_q   <= '0;
      presc_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      sec_q    <= sec_d;
      glen_q   <= glen_d;
      presc_q  <= presc_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_WAYS; i++) begin
      lights[i*3 +: 3] = 3'b100;
      if (AW'(i) == active_q) begin
        if (phase_q == PH_GREEN)
          lights[i*3 +: 3] = 3'b001;
        else if (phase_q == PH_YELLOW)
          lights[i*3 +: 3] = 3'b010;
      end
    end
  end

  assign active_way = active_q;
  assign sec_left   = sec_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_controller_nway.sv
// Directed bench for traffic_controller_nway with a 4-cycle second and 4 approaches.
module tb_traffic_controller_nway;

  localparam int NW = 4;
  localparam int CW = 4;

  logic              clk_50MHz = 1'b0;
  logic              reset;
  logic [NW*CW-1:0]  count;
  logic [NW*3-1:0]   lights;
  logic [1:0]        active_way;
  logic [7:0]        sec_left;
  logic [1:0]        phase;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] AR = 2'b00;
  localparam logic [1:0] GR = 2'b01;
  localparam logic [1:0] YE = 2'b10;

  traffic_controller_nway #(
    .N_WAYS(NW), .CNT_W(CW), .TICK_DIV(4), .MIN_GREEN(2), .MAX_GREEN(6),
    .SEC_PER_CAR(1), .YELLOW_T(1), .ALL_RED_T(1)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .count     (count),
    .lights    (lights),
    .active_way(active_way),
    .sec_left  (sec_left),
    .phase     (phase)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  // Every cycle: each approach shows exactly one lamp and at most one approach is non-red.
  always @(negedge clk_50MHz) begin
    int nonred;
    logic [2:0] grp;
    nonred = 0;
    for (int i = 0; i < NW; i++) begin
      grp = lights[i*3 +: 3];
      total++;
      assert ($onehot(grp)) else begin
        bad++;
        $error("FAIL onehot_way%0d got=%b exp=onehot", i, grp);
      end
      if (grp != 3'b100) nonred++;
    end
    total++;
    assert (nonred <= 1) else begin
      bad++;
      $error("FAIL safety nonred got=%0d exp<=1", nonred);
    end
  end

  function automatic logic [NW*3-1:0] lamps(input logic [1:0] ph, input int way);
    logic [NW*3-1:0] l;
    l = {NW{3'b100}};
    if (ph == GR) l[way*3 +: 3] = 3'b001;
    if (ph == YE) l[way*3 +: 3] = 3'b010;
    return l;
  endfunction

  task automatic adv(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
    count = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
  endtask

  task automatic chk(input string tag, input logic [1:0] ph, input int way, input int sec);
    total++;
    assert (phase === ph) else begin
      bad++;
      $error("FAIL %s phase got=%b exp=%b", tag, phase, ph);
    end
    total++;
    assert (active_way === 2'(way)) else begin
      bad++;
      $error("FAIL %s active_way got=%0d exp=%0d", tag, active_way, way);
    end
    total++;
    assert (sec_left === 8'(sec)) else begin
      bad++;
      $error("FAIL %s sec_left got=%0d exp=%0d", tag, sec_left, sec);
    end
    total++;
    assert (lights === lamps(ph, way)) else begin
      bad++;
      $error("FAIL %s lights got=%b exp=%b", tag, lights, lamps(ph, way));
    end
  endtask

  task automatic restart();
    reset = 1'b0;
    adv(2);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_counts(3, 0, 0, 0);
    adv(2);
    reset = 1'b1;

    // Single busy approach: way0 served repeatedly.
    chk("t1_reset", AR, 3, 1);
    adv(3); chk("t1_ar_hold", AR, 3, 1);
    adv(1); chk("t1_g0_start", GR, 0, 3);
    adv(11); chk("t1_g0_last", GR, 0, 1);
    adv(1); chk("t1_y0", YE, 0, 1);
    adv(3); chk("t1_y0_last", YE, 0, 1);
    adv(1); chk("t1_ar", AR, 0, 1);
    adv(4); chk("t1_g0_again", GR, 0, 3);

    // Skip empty approaches: order 1,3,1,3.
    set_counts(0, 5, 0, 2);
    restart();
    chk("t2_reset", AR, 3, 1);
    adv(4); chk("t2_g1", GR, 1, 5);
    adv(4); chk("t2_g1_4s", GR, 1, 4);
    adv(16); chk("t2_y1", YE, 1, 1);
    adv(4); chk("t2_ar1", AR, 1, 1);
    adv(4); chk("t2_g3", GR, 3, 2);
    adv(8); chk("t2_y3", YE, 3, 1);
    adv(8); chk("t2_g1_b", GR, 1, 5);
    adv(20); chk("t2_y1_b", YE, 1, 1);
    adv(8); chk("t2_g3_b", GR, 3, 2);

    // Clamping to MAX_GREEN and MIN_GREEN.
    set_counts(0, 0, 15, 0);
    restart();
    adv(4); chk("t3_g2_max", GR, 2, 6);
    adv(23); chk("t3_g2_last", GR, 2, 1);
    adv(1); chk("t3_y2", YE, 2, 1);
    set_counts(0, 0, 1, 0);
    adv(8); chk("t3_g2_min", GR, 2, 2);
    adv(8); chk("t3_y2_min", YE, 2, 1);

    // Early exit when the queue empties after MIN_GREEN.
    set_counts(0, 5, 0, 0);
    restart();
    adv(4); chk("t4_g1", GR, 1, 5);
    adv(8); chk("t4_g1_2s", GR, 1, 3);
    set_counts(0, 0, 0, 0);
    adv(3); chk("t4_g1_hold", GR, 1, 3);
    adv(1); chk("t4_y1_early", YE, 1, 1);

    // All empty: plain rotation, MIN_GREEN each.
    set_counts(0, 0, 0, 0);
    restart();
    adv(4);
    for (int w = 0; w < 5; w++) begin
      chk($sformatf("t5_g%0d", w % 4), GR, w % 4, 2);
      adv(4); chk($sformatf("t5_g%0d_1s", w % 4), GR, w % 4, 1);
      adv(4); chk($sformatf("t5_y%0d", w % 4), YE, w % 4, 1);
      adv(4); chk($sformatf("t5_ar%0d", w % 4), AR, w % 4, 1);
      adv(4);
    end

    // Asynchronous reset during yellow; counts changed while held.
    set_counts(3, 0, 0, 0);
    restart();
    adv(4); chk("t6_g0", GR, 0, 3);
    adv(12); chk("t6_y0", YE, 0, 1);
    adv(2);
    reset = 1'b0;
    #1;
    chk("t6_async_rst", AR, 3, 1);
    set_counts(0, 0, 4, 0);
    adv(1);
    reset = 1'b1;
    chk("t6_rst_held", AR, 3, 1);
    adv(4); chk("t6_g2_new", GR, 2, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
